// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) round-robin arbiter onto one
// single-port memory with variable-latency ack and a per-grant timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last counter value of a grant; no ack here means the grant has used up
  // its TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_D  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       last_gnt;
  logic [CNT_W-1:0] wait_cnt;

  logic in_gnt;
  logic if_cand;
  logic d_cand;
  logic pick_d;
  logic grant;
  logic timeout_hit;
  logic finish;

  // Arbitration and completion decode; a port whose done is high this cycle
  // is held out so a still-asserted req is not serviced a second time.
  always_comb begin
    in_gnt      = (state == GNT_IF) || (state == GNT_D);
    if_cand     = if_req & ~if_done;
    d_cand      = d_req & ~d_done;
    pick_d      = d_cand & (~if_cand | (last_gnt == GNT_IF));
    grant       = (state == IDLE) & (if_cand | d_cand);
    timeout_hit = in_gnt & ~mem_ack & (wait_cnt == CNT_LAST);
    finish      = in_gnt & (mem_ack | timeout_hit);
  end

  assign mem_req = in_gnt;
  assign busy    = (state != IDLE);

  // FSM and round-robin history (history only moves on contention)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= GNT_IF;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= pick_d ? GNT_D : GNT_IF;
            if (if_cand && d_cand) last_gnt <= pick_d ? GNT_D : GNT_IF;
          end
        end
        GNT_IF, GNT_D: begin
          if (finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-grant wait counter; stops short of TIMEOUT so it can never wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (grant) begin
      wait_cnt <= '0;
    end else if (in_gnt && !finish) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Request latch: captured once at grant, drives the memory port unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      mem_we    <= pick_d & d_we;
      mem_addr  <= pick_d ? d_addr : if_addr;
      mem_wdata <= pick_d ? d_wdata : '0;
    end
  end

  // Completion: owner's done pulse, read data capture, sticky timeout error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      if_done <= finish & (state == GNT_IF);
      d_done  <= finish & (state == GNT_D);
      if (in_gnt && mem_ack && !mem_we) begin
        if (state == GNT_IF) if_rdata <= mem_rdata;
        else                 d_rdata  <= mem_rdata;
      end
      if (timeout_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // memory contents seen by the responder
  logic [31:0] memarr [logic [31:0]];

  // reference model: current owner (0 none, 1 fetch, 2 data), cycles waited,
  // last contention winner, captured request, expected outputs
  int          m_owner, m_wait, m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic        e_if_done, e_d_done, e_err;
  logic [31:0] e_if_rdata, e_d_rdata;

  // requester agents
  logic if_pend, d_pend;
  int   if_left, d_left, if_rate, d_rate;
  bit   rnd;

  // memory responder
  int lat_cfg, cur_lat, gcyc;
  bit idle_ack_en;

  // observation log
  int          cyc, if_start, d_start, if_lat, d_lat, mreq_n;
  int          done_q[$];
  logic        obs_we[$];
  logic [31:0] obs_wdata[$];
  logic        prev_mreq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (memarr.exists(a)) return memarr[a];
    return {a[15:0], 16'hbeef};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = 32'h40;
      1: t = 32'h44;
      2: t = 32'h100;
      default: t = 32'h104;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_last = 1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    e_if_done = 1'b0; e_d_done = 1'b0; e_err = 1'b0;
    e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic clr();
    done_q.delete(); obs_we.delete(); obs_wdata.delete();
    mreq_n = 0; if_lat = -1; d_lat = -1;
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_owner != 0);
    chk("busy", busy, m_owner != 0);
    chk("if_done", if_done, e_if_done);
    chk("d_done", d_done, e_d_done);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("err", err, e_err);
    chk("done_excl", if_done & d_done, 1'b0);
    if (m_owner != 0) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (mem_req) mreq_n++;
    if (mem_req && !prev_mreq) begin
      obs_we.push_back(mem_we);
      obs_wdata.push_back(mem_wdata);
    end
    prev_mreq = mem_req;
    if (if_done) begin done_q.push_back(1); if_lat = cyc - if_start; end
    if (d_done)  begin done_q.push_back(2); d_lat  = cyc - d_start;  end
  endtask

  // requesters hold their request until done; memory acks after a latency
  task automatic drive();
    if (e_if_done) if_pend = 1'b0;
    if (e_d_done)  d_pend  = 1'b0;
    if (!if_pend && if_left > 0 && int'($urandom_range(0, 99)) < if_rate) begin
      if_pend = 1'b1; if_left--; if_start = cyc;
      if (rnd) if_addr = rand_addr();
    end
    if (!d_pend && d_left > 0 && int'($urandom_range(0, 99)) < d_rate) begin
      d_pend = 1'b1; d_left--; d_start = cyc;
      if (rnd) begin
        d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
    end
    if_req = if_pend;
    d_req  = d_pend;
    if (mem_req) begin
      if (gcyc == 0) cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 5)) : lat_cfg;
      mem_ack   = (gcyc == cur_lat);
      mem_rdata = mem_ack ? rd(mem_addr) : $urandom;
      if (mem_ack && mem_we) memarr[mem_addr] = mem_wdata;
      gcyc++;
    end else begin
      gcyc = 0;
      mem_ack   = idle_ack_en && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  // what the next rising edge must do, from the arbitration rules
  task automatic model_edge();
    logic ci, cd, ndi, ndd;
    int   g;
    ndi = 1'b0; ndd = 1'b0;
    ci = if_req && !e_if_done;
    cd = d_req && !e_d_done;
    if (m_owner != 0) begin
      if (mem_ack || (m_wait + 1 == TO)) begin
        if (m_owner == 1) ndi = 1'b1; else ndd = 1'b1;
        if (mem_ack) begin
          if (!m_we) begin
            if (m_owner == 1) e_if_rdata = rd(m_addr);
            else              e_d_rdata  = rd(m_addr);
          end
        end else begin
          e_err = 1'b1;
        end
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end else begin
      g = 0;
      if (ci && cd) begin g = (m_last == 1) ? 2 : 1; m_last = g; end
      else if (ci) g = 1;
      else if (cd) g = 2;
      if (g == 1) begin m_we = 1'b0; m_addr = if_addr; m_wdata = '0; end
      else if (g == 2) begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
      if (g != 0) begin m_owner = g; m_wait = 0; end
    end
    e_if_done = ndi;
    e_d_done  = ndd;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      check_all();
      drive();
      model_edge();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    if_pend = 1'b0; d_pend = 1'b0; if_req = 1'b0; d_req = 1'b0;
    mem_ack = 1'b0; if_left = 0; d_left = 0; gcyc = 0;
    model_reset();
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", {if_done, d_done}, 2'b00);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    prev_mreq = 1'b0;
  endtask

  initial begin
    cyc = 0; rnd = 1'b0; lat_cfg = 0; idle_ack_en = 1'b0;
    if_rate = 100; d_rate = 100; prev_mreq = 1'b0;
    clr();

    // fetch only, zero-latency ack
    memarr[32'h100] = 32'h00500093;
    do_reset(); clr();
    if_addr = 32'h100; if_left = 1;
    run(6);
    chk("A_if_rdata", if_rdata, 32'h00500093);
    chk("A_mreq_cycles", mreq_n, 1);
    chk("A_latency", if_lat, 2);
    chk("A_grants", obs_we.size(), 1);
    chk("A_we", obs_we[0], 1'b0);

    // simultaneous first requests: data wins, then fetch
    memarr[32'h104] = 32'h0badf00d;
    do_reset(); clr();
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; if_addr = 32'h104;
    if_left = 1; d_left = 1;
    run(8);
    chk("B_ndone", done_q.size(), 2);
    chk("B_first", done_q[0], 2);
    chk("B_second", done_q[1], 1);
    chk("B_we0", obs_we[0], 1'b1);
    chk("B_wdata0", obs_wdata[0], 32'hA5A5A5A5);
    chk("B_we1", obs_we[1], 1'b0);
    chk("B_if_rdata", if_rdata, 32'h0badf00d);

    // both held, ack latency 2: strict alternation D, IF, D, IF ...
    do_reset(); clr();
    d_we = 1'b0; d_addr = 32'h40; if_addr = 32'h100; lat_cfg = 2;
    if_left = 3; d_left = 3;
    run(40);
    chk("C_ndone", done_q.size(), 6);
    chk("C_ngrants", obs_we.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("C_order%0d", i), done_q[i], (i % 2 == 0) ? 2 : 1);

    // ack in the last allowed cycle succeeds, then a load that times out
    memarr[32'h48] = 32'h11223344;
    do_reset(); clr();
    d_we = 1'b0; d_addr = 32'h48; lat_cfg = 3; d_left = 1;
    run(8);
    chk("D_late_rdata", d_rdata, 32'h11223344);
    chk("D_late_err", err, 1'b0);
    chk("D_late_mreq", mreq_n, 4);
    clr(); lat_cfg = 100; d_left = 1;
    run(10);
    chk("D_to_mreq", mreq_n, 4);
    chk("D_to_ndone", done_q.size(), 1);
    chk("D_to_owner", done_q[0], 2);
    chk("D_to_rdata", d_rdata, 32'h11223344);
    chk("D_to_err", err, 1'b1);
    run(5);
    chk("D_err_sticky", err, 1'b1);

    // reset in the middle of a data grant
    do_reset(); clr();
    d_we = 1'b1; d_addr = 32'h4c; d_wdata = 32'hdeadbeef; lat_cfg = 100; d_left = 1;
    run(3);
    chk("E_in_grant", mreq_n, 2);
    clr();
    do_reset();
    chk("E_no_done", done_q.size(), 0);
    clr(); lat_cfg = 1; d_left = 1;
    run(8);
    chk("E_after_ndone", done_q.size(), 1);
    chk("E_after_lat", d_lat, 3);
    chk("E_after_err", err, 1'b0);

    // randomized traffic, random latencies (some time out), stray idle acks
    do_reset(); clr();
    rnd = 1'b1; lat_cfg = -1; idle_ack_en = 1'b1;
    if_left = 100000; d_left = 100000; if_rate = 40; d_rate = 40;
    run(1500);
    chk("R_activity", done_q.size() > 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both requesters and the memory port.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack per grant; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 if_req  input  1  instruction-fetch read request; held with if_addr stable until if_done.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched word, valid while if_done=1.
REQ-009 if_done  output  1  one-cycle completion pulse for fetch port.
REQ-010 d_req  input  1  data-port request; held with d_we, d_addr and d_wdata stable until d_done.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  load/store address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdata  output  DATA_W  load data, valid while d_done=1.
REQ-015 d_done  output  1  one-cycle completion pulse for data port.
REQ-016 mem_req  output  1  request to the shared single-port memory.
REQ-017 mem_we  output  1  write enable to memory.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-021 mem_ack  input  1  memory completion; variable latency of 0 or more cycles after mem_req rises.
REQ-022 busy  output  1  1 when state is not IDLE.
REQ-023 err  output  1  sticky timeout flag.

Function
REQ-024 The FSM SHALL have three states: IDLE, GNT_IF and GNT_D.
REQ-025 In IDLE with one unmasked request, the FSM SHALL move to that port's GNT state at the next edge.
REQ-026 In IDLE with both ports requesting, the FSM SHALL grant the port not recorded in register last_gnt (round-robin) and update last_gnt to the granted port.
REQ-027 At grant, the block SHALL latch we, addr and wdata (for fetch: we=0, wdata=0); mem_* outputs SHALL be registered from the latch and SHALL stay stable for the whole grant.
REQ-028 mem_req SHALL be 1 exactly while in GNT_IF or GNT_D.
REQ-029 mem_ack sampled 1 in a GNT state SHALL cause the following:
- Return to IDLE at that edge.
- A one-cycle pulse of the owner's done in the next cycle.
- On a read, owner's rdata loaded with mem_rdata; on a write, rdata unchanged.
REQ-030 mem_ack sampled while in IDLE SHALL be ignored.
REQ-031 A port's req SHALL be masked from arbitration during the cycle its done is 1, so a held req is not serviced twice.
REQ-032 Minimum latency SHALL be as follows:
- req sampled at edge E0.
- mem_req=1 in the cycle after E0.
- With ack in that cycle, done=1 in the cycle after E0+1.
- Total of 2 cycles from request to done.
REQ-033 A wait counter SHALL clear at grant and increment each GNT cycle without ack.
REQ-034 If the wait counter reaches TIMEOUT without an ack, the grant SHALL abort: return to IDLE, owner's done pulses, owner's rdata unchanged, err set to 1.
REQ-035 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as success (no err).
REQ-036 err SHALL remain 1 until reset.
REQ-037 The wait counter width SHALL be clog2(TIMEOUT+1) bits and SHALL never wrap.
REQ-038 if_done and d_done SHALL never be 1 in the same cycle.

Reset
REQ-039 While reset=0, asynchronously and regardless of state (including mid-grant), the block SHALL drive:
- state IDLE, last_gnt = GNT_IF, so first contention goes to data.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- if_done=0, d_done=0, if_rdata=0, d_rdata=0.
- busy=0, err=0, wait counter 0.
REQ-040 A transaction interrupted by reset SHALL produce no done pulse.
REQ-041 Arbitration SHALL resume at the first rising edge after reset returns to 1.

Verification
REQ-042 Fetch only, if_addr=0x100, ack same cycle with mem_rdata=0x00500093 -> mem_req 1 cycle, mem_we=0, if_done 2 cycles after req, if_rdata=0x00500093.
REQ-043 if_req and d_req together after reset, d_we=1, d_addr=0x40, d_wdata=0xA5A5A5A5 -> data granted first, mem_we=1, mem_wdata=0xA5A5A5A5; fetch granted next; if_done follows d_done.
REQ-044 Both reqs held high continuously, ack latency 2 -> grants alternate D, IF, D, IF; no double service per done.
REQ-045 TIMEOUT=4, d_req load, mem_ack never -> mem_req high 4 cycles, d_done pulses, d_rdata unchanged, err=1 and stays 1.
REQ-046 reset driven 0 mid-GNT_D -> mem_req=0 and busy=0 immediately, no d_done; after release, a new d_req completes normally.
